// File: rtl/axi_sram_slave_pkg.sv
// Shared AXI codes, FSM state types and burst address helper for the AXI SRAM slave.
package axi_sram_slave_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE  = 2'd0,
    R_FETCH = 2'd1,
    R_DATA  = 2'd2
  } r_state_e;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } w_state_e;

  // WRAP is deliberately treated as INCR; FIXED re-uses the same word.
  function automatic logic [31:0] next_beat_addr(input logic [31:0] addr,
                                                 input logic [1:0]  burst);
    logic [31:0] nxt;
    case (burst)
      BURST_FIXED: nxt = addr;
      BURST_INCR:  nxt = addr + 32'd4;
      BURST_WRAP:  nxt = addr + 32'd4;
      default:     nxt = addr + 32'd4;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/axi_sram_slave_sram.sv
// Synchronous 1-read/1-write word RAM with byte enables, read-first, 1-cycle read latency.
module sram_1r1w #(
  parameter  int DEPTH = 16384,
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic          clk,
  input  logic          i_re,
  input  logic [AW-1:0] i_raddr,
  output logic [31:0]   o_rdata,
  input  logic          i_we,
  input  logic [AW-1:0] i_waddr,
  input  logic [3:0]    i_wbe,
  input  logic [31:0]   i_wdata
);

  logic [31:0] r_mem [DEPTH];
  logic [31:0] r_rdata;

  // Both ports update with non-blocking writes, so a same-edge read sees the old word.
  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int b = 0; b < 4; b++) begin
        if (i_wbe[b]) r_mem[i_waddr][b*8 +: 8] <= i_wdata[b*8 +: 8];
      end
    end
    if (i_re) r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/axi_sram_slave.sv
// AXI3 slave backed by on-chip word memory; independent read and write FSMs, DECERR outside memory.
module axi_sram_slave
  import axi_sram_slave_pkg::*;
#(
  parameter int ADDR_W = 14
) (
  input  logic        clk,
  input  logic        resetn,
  // read address
  input  logic [3:0]  arid,
  input  logic [31:0] araddr,
  input  logic [7:0]  arlen,
  input  logic [2:0]  arsize,
  input  logic [1:0]  arburst,
  input  logic [1:0]  arlock,
  input  logic [3:0]  arcache,
  input  logic [2:0]  arprot,
  input  logic        arvalid,
  output logic        arready,
  // read data
  output logic [3:0]  rid,
  output logic [31:0] rdata,
  output logic [1:0]  rresp,
  output logic        rlast,
  output logic        rvalid,
  input  logic        rready,
  // write address
  input  logic [3:0]  awid,
  input  logic [31:0] awaddr,
  input  logic [7:0]  awlen,
  input  logic [2:0]  awsize,
  input  logic [1:0]  awburst,
  input  logic [1:0]  awlock,
  input  logic [3:0]  awcache,
  input  logic [2:0]  awprot,
  input  logic        awvalid,
  output logic        awready,
  // write data
  input  logic [3:0]  wid,
  input  logic [31:0] wdata,
  input  logic [3:0]  wstrb,
  input  logic        wlast,
  input  logic        wvalid,
  output logic        wready,
  // write response
  output logic [3:0]  bid,
  output logic [1:0]  bresp,
  output logic        bvalid,
  input  logic        bready,
  // FSM observability
  output logic [1:0]  o_dbg_rstate,
  output logic [1:0]  o_dbg_wstate
);

  localparam int DEPTH = 1 << ADDR_W;

  // Handshake rule: a transfer happens on a rising edge where valid and ready are both high;
  // a source holds valid and its payload steady until that edge.

  logic        r_init;

  r_state_e    r_rstate;
  r_state_e    w_rstate_nxt;
  logic [3:0]  r_rid;
  logic [31:0] r_raddr;
  logic [7:0]  r_rlen;
  logic [7:0]  r_rcnt;
  logic [1:0]  r_rburst;
  logic [31:0] r_rdata;
  logic [1:0]  r_rresp;

  w_state_e    r_wstate;
  w_state_e    w_wstate_nxt;
  logic [3:0]  r_bid;
  logic [31:0] r_waddr;
  logic [7:0]  r_wlen;
  logic [7:0]  r_wcnt;
  logic [1:0]  r_wburst;
  logic        r_dec_err;
  logic        r_slv_err;

  logic              w_ren;
  logic [ADDR_W-1:0] w_rword;
  logic [31:0]       w_mem_rdata;
  logic [31:0]       w_raddr_adv;
  logic              w_rlast_beat;
  logic              w_rd_in_range;

  logic              w_we;
  logic              w_whs;
  logic [31:0]       w_waddr_adv;
  logic              w_wlast_beat;
  logic              w_wr_in_range;

  logic              w_unused;

  assign w_unused = ^{arsize, arlock, arcache, arprot, awsize, awlock, awcache, awprot, wid};

  // Ready is withheld until the first edge after reset release.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) r_init <= 1'b0;
    else         r_init <= 1'b1;
  end

  // ---------------- read channel ----------------
  assign w_raddr_adv   = next_beat_addr(r_raddr, r_rburst);
  assign w_rlast_beat  = (r_rcnt == r_rlen);
  assign w_rd_in_range = (r_raddr[31:ADDR_W+2] == '0);

  assign arready = (r_rstate == R_IDLE) && r_init;
  assign rvalid  = (r_rstate == R_DATA);
  assign rlast   = (r_rstate == R_DATA) && w_rlast_beat;
  assign rid     = r_rid;
  assign rdata   = r_rdata;
  assign rresp   = r_rresp;

  always_comb begin
    w_rstate_nxt = r_rstate;
    w_ren        = 1'b0;
    w_rword      = r_raddr[ADDR_W+1:2];
    case (r_rstate)
      R_IDLE: begin
        if (arvalid && arready) begin
          w_rstate_nxt = R_FETCH;
          w_ren        = 1'b1;
          w_rword      = araddr[ADDR_W+1:2];
        end
      end
      R_FETCH: w_rstate_nxt = R_DATA;
      R_DATA: begin
        if (rready) begin
          if (w_rlast_beat) begin
            w_rstate_nxt = R_IDLE;
          end else begin
            w_rstate_nxt = R_FETCH;
            w_ren        = 1'b1;
            w_rword      = w_raddr_adv[ADDR_W+1:2];
          end
        end
      end
      default: w_rstate_nxt = R_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_rstate <= R_IDLE;
      r_rid    <= '0;
      r_raddr  <= '0;
      r_rlen   <= '0;
      r_rcnt   <= '0;
      r_rburst <= '0;
      r_rdata  <= '0;
      r_rresp  <= '0;
    end else begin
      r_rstate <= w_rstate_nxt;
      case (r_rstate)
        R_IDLE: begin
          if (arvalid && arready) begin
            r_rid    <= arid;
            r_raddr  <= araddr;
            r_rlen   <= arlen;
            r_rburst <= arburst;
            r_rcnt   <= '0;
          end
        end
        // rdata/rresp only change here, so they stay put while the master stalls rready.
        R_FETCH: begin
          r_rdata <= w_rd_in_range ? w_mem_rdata : 32'd0;
          r_rresp <= w_rd_in_range ? RESP_OKAY : RESP_DECERR;
        end
        R_DATA: begin
          if (rready && !w_rlast_beat) begin
            r_raddr <= w_raddr_adv;
            r_rcnt  <= r_rcnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

  // ---------------- write channel ----------------
  assign w_waddr_adv   = next_beat_addr(r_waddr, r_wburst);
  assign w_wlast_beat  = (r_wcnt == r_wlen);
  assign w_wr_in_range = (r_waddr[31:ADDR_W+2] == '0);
  assign w_whs         = (r_wstate == W_DATA) && wvalid;
  assign w_we          = w_whs && w_wr_in_range;

  assign awready = (r_wstate == W_IDLE) && r_init;
  assign wready  = (r_wstate == W_DATA);
  assign bvalid  = (r_wstate == W_RESP);
  assign bid     = r_bid;
  assign bresp   = r_dec_err ? RESP_DECERR : (r_slv_err ? RESP_SLVERR : RESP_OKAY);

  always_comb begin
    w_wstate_nxt = r_wstate;
    case (r_wstate)
      W_IDLE:  if (awvalid && awready) w_wstate_nxt = W_DATA;
      W_DATA:  if (wvalid && w_wlast_beat) w_wstate_nxt = W_RESP;
      W_RESP:  if (bready) w_wstate_nxt = W_IDLE;
      default: w_wstate_nxt = W_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wstate  <= W_IDLE;
      r_bid     <= '0;
      r_waddr   <= '0;
      r_wlen    <= '0;
      r_wcnt    <= '0;
      r_wburst  <= '0;
      r_dec_err <= 1'b0;
      r_slv_err <= 1'b0;
    end else begin
      r_wstate <= w_wstate_nxt;
      case (r_wstate)
        W_IDLE: begin
          if (awvalid && awready) begin
            r_bid     <= awid;
            r_waddr   <= awaddr;
            r_wlen    <= awlen;
            r_wburst  <= awburst;
            r_wcnt    <= '0;
            r_dec_err <= 1'b0;
            r_slv_err <= 1'b0;
          end
        end
        // The beat count, not wlast, decides where the burst ends; wlast is only audited.
        W_DATA: begin
          if (wvalid) begin
            if (!w_wr_in_range)         r_dec_err <= 1'b1;
            if (wlast != w_wlast_beat)  r_slv_err <= 1'b1;
            if (!w_wlast_beat) begin
              r_waddr <= w_waddr_adv;
              r_wcnt  <= r_wcnt + 8'd1;
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign o_dbg_rstate = r_rstate;
  assign o_dbg_wstate = r_wstate;

  sram_1r1w #(.DEPTH(DEPTH)) u_sram (
    .clk     (clk),
    .i_re    (w_ren),
    .i_raddr (w_rword),
    .o_rdata (w_mem_rdata),
    .i_we    (w_we),
    .i_waddr (r_waddr[ADDR_W+1:2]),
    .i_wbe   (wstrb),
    .i_wdata (wdata)
  );

endmodule

// File: tb/tb_axi_sram_slave.sv
// Directed bench for axi_sram_slave: queued expected R/B responses checked by a negedge monitor.
module tb_axi_sram_slave;
  import axi_sram_slave_pkg::*;

  localparam int ADDR_W = 14;

  logic        clk;
  logic        resetn;
  logic [3:0]  arid;
  logic [31:0] araddr;
  logic [7:0]  arlen;
  logic [2:0]  arsize;
  logic [1:0]  arburst;
  logic [1:0]  arlock;
  logic [3:0]  arcache;
  logic [2:0]  arprot;
  logic        arvalid;
  logic        arready;
  logic [3:0]  rid;
  logic [31:0] rdata;
  logic [1:0]  rresp;
  logic        rlast;
  logic        rvalid;
  logic        rready;
  logic [3:0]  awid;
  logic [31:0] awaddr;
  logic [7:0]  awlen;
  logic [2:0]  awsize;
  logic [1:0]  awburst;
  logic [1:0]  awlock;
  logic [3:0]  awcache;
  logic [2:0]  awprot;
  logic        awvalid;
  logic        awready;
  logic [3:0]  wid;
  logic [31:0] wdata;
  logic [3:0]  wstrb;
  logic        wlast;
  logic        wvalid;
  logic        wready;
  logic [3:0]  bid;
  logic [1:0]  bresp;
  logic        bvalid;
  logic        bready;
  logic [1:0]  dbg_rstate;
  logic [1:0]  dbg_wstate;

  axi_sram_slave #(.ADDR_W(ADDR_W)) dut (
    .clk(clk), .resetn(resetn),
    .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
    .arlock(arlock), .arcache(arcache), .arprot(arprot), .arvalid(arvalid), .arready(arready),
    .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
    .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
    .awlock(awlock), .awcache(awcache), .awprot(awprot), .awvalid(awvalid), .awready(awready),
    .wid(wid), .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
    .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
    .o_dbg_rstate(dbg_rstate), .o_dbg_wstate(dbg_wstate)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // ---------------- scoreboard ----------------
  int checks = 0;
  int errors = 0;
  logic [38:0] r_exp_q[$];   // {rid, rdata, rresp, rlast}
  logic [5:0]  b_exp_q[$];   // {bid, bresp}
  logic        r_hold;
  logic        b_hold;
  logic [38:0] r_prev;
  logic [5:0]  b_prev;
  logic        rr_toggle;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic push_r(input logic [3:0] id, input logic [31:0] data, input logic [1:0] resp,
                        input logic last);
    r_exp_q.push_back({id, data, resp, last});
  endtask

  task automatic push_b(input logic [3:0] id, input logic [1:0] resp);
    b_exp_q.push_back({id, resp});
  endtask

  always @(negedge clk) begin
    if (!resetn) begin
      r_hold = 1'b0;
      b_hold = 1'b0;
    end else begin
      if (rvalid) begin
        if (r_hold) check("r_stable", 64'({rid, rdata, rresp, rlast}), 64'(r_prev));
        if (rready) begin
          if (r_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL r_unexpected actual=%h expected=none", {rid, rdata, rresp, rlast});
          end else begin
            check("r_beat", 64'({rid, rdata, rresp, rlast}), 64'(r_exp_q.pop_front()));
          end
          r_hold = 1'b0;
        end else begin
          r_hold = 1'b1;
          r_prev = {rid, rdata, rresp, rlast};
        end
      end else begin
        r_hold = 1'b0;
      end
      if (bvalid) begin
        if (b_hold) check("b_stable", 64'({bid, bresp}), 64'(b_prev));
        if (bready) begin
          if (b_exp_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL b_unexpected actual=%h expected=none", {bid, bresp});
          end else begin
            check("b_resp", 64'({bid, bresp}), 64'(b_exp_q.pop_front()));
          end
          b_hold = 1'b0;
        end else begin
          b_hold = 1'b1;
          b_prev = {bid, bresp};
        end
      end else begin
        b_hold = 1'b0;
      end
    end
  end

  // ---------------- drivers ----------------
  initial begin
    rready = 1'b1;
    forever begin
      @(posedge clk); #1;
      rready = rr_toggle ? ~rready : 1'b1;
    end
  end

  task automatic ar_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (arready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    arvalid = 1'b0;
    check("ar_handshake", 64'(ok), 64'd1);
  endtask

  task automatic aw_send(input logic [3:0] id, input logic [31:0] addr, input logic [7:0] len,
                         input logic [1:0] burst);
    logic ok;
    ok = 1'b0;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (awready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    awvalid = 1'b0;
    check("aw_handshake", 64'(ok), 64'd1);
  endtask

  task automatic w_send(input logic [31:0] data, input logic [3:0] strb, input logic last);
    logic ok;
    ok = 1'b0;
    wdata = data; wstrb = strb; wlast = last; wvalid = 1'b1;
    for (int i = 0; i < 50; i++) begin
      @(negedge clk);
      if (wready) begin ok = 1'b1; break; end
    end
    @(posedge clk); #1;
    wvalid = 1'b0;
    check("w_handshake", 64'(ok), 64'd1);
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((r_exp_q.size() != 0 || b_exp_q.size() != 0) && n < 200) begin
      @(negedge clk);
      n++;
    end
    check("drain_done", 64'(n < 200), 64'd1);
    if (n >= 200) begin
      r_exp_q.delete();
      b_exp_q.delete();
    end
    @(posedge clk); #1;
  endtask

  task automatic write1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                        input logic [3:0] strb, input logic [1:0] resp);
    push_b(id, resp);
    aw_send(id, addr, 8'd0, BURST_INCR);
    w_send(data, strb, 1'b1);
    drain();
  endtask

  task automatic read1(input logic [3:0] id, input logic [31:0] addr, input logic [31:0] data,
                       input logic [1:0] resp);
    push_r(id, data, resp, 1'b1);
    ar_send(id, addr, 8'd0, BURST_INCR);
    drain();
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    resetn = 1'b0; rr_toggle = 1'b0; bready = 1'b1;
    arid = '0; araddr = '0; arlen = '0; arsize = 3'd2; arburst = BURST_INCR;
    arlock = '0; arcache = '0; arprot = '0; arvalid = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awsize = 3'd2; awburst = BURST_INCR;
    awlock = '0; awcache = '0; awprot = '0; awvalid = 1'b0;
    wid = 4'hF; wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset_outputs", 64'({arready, awready, wready, rvalid, rlast, bvalid, rid, bid,
                                rresp, bresp, rdata, dbg_rstate, dbg_wstate}), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(negedge clk);
    check("ready_before_init", 64'({arready, awready}), 64'd0);
    @(negedge clk);
    check("ready_after_init", 64'({arready, awready}), 64'b11);
    @(posedge clk); #1;

    // single-beat write then read with latency checks
    aw_send(4'd1, 32'h100, 8'd0, BURST_INCR);
    @(negedge clk);
    check("awready_busy", 64'(awready), 64'd0);
    check("wready_t1", 64'(wready), 64'd1);
    check("dbg_wstate", 64'(dbg_wstate), 64'(W_DATA));
    @(posedge clk); #1;
    push_b(4'd1, RESP_OKAY);
    w_send(32'hDEADBEEF, 4'hF, 1'b1);
    @(negedge clk);
    check("bvalid_t1", 64'(bvalid), 64'd1);
    drain();
    push_r(4'd0, 32'hDEADBEEF, RESP_OKAY, 1'b1);
    ar_send(4'd0, 32'h100, 8'd0, BURST_INCR);
    @(negedge clk);
    check("rvalid_t1", 64'(rvalid), 64'd0);
    check("arready_busy", 64'(arready), 64'd0);
    @(negedge clk);
    check("rvalid_t2", 64'(rvalid), 64'd1);
    drain();

    // byte strobes
    write1(4'd2, 32'h104, 32'h11223344, 4'hF, RESP_OKAY);
    write1(4'd3, 32'h104, 32'hAABBCCDD, 4'h5, RESP_OKAY);
    read1(4'd4, 32'h104, 32'h11BB33DD, RESP_OKAY);

    // INCR burst write, then burst read under toggling rready
    push_b(4'd5, RESP_OKAY);
    aw_send(4'd5, 32'h200, 8'd3, BURST_INCR);
    for (int i = 0; i < 4; i++) w_send(32'hCAFE0000 + 32'(i), 4'hF, i == 3);
    drain();
    for (int i = 0; i < 4; i++) push_r(4'd6, 32'hCAFE0000 + 32'(i), RESP_OKAY, i == 3);
    rr_toggle = 1'b1;
    ar_send(4'd6, 32'h200, 8'd3, BURST_INCR);
    drain();
    rr_toggle = 1'b0;

    // out-of-range read and write; aliased word 0 must survive
    write1(4'd7, 32'h0, 32'h01234567, 4'hF, RESP_OKAY);
    read1(4'd8, 32'h1 << (ADDR_W + 2), 32'h0, RESP_DECERR);
    write1(4'd9, 32'h1 << (ADDR_W + 2), 32'h55555555, 4'hF, RESP_DECERR);
    read1(4'd10, 32'h0, 32'h01234567, RESP_OKAY);

    // wlast asserted early: both beats still land, SLVERR reported
    push_b(4'd11, RESP_SLVERR);
    aw_send(4'd11, 32'h300, 8'd1, BURST_INCR);
    w_send(32'h00001111, 4'hF, 1'b1);
    w_send(32'h00002222, 4'hF, 1'b1);
    drain();
    push_r(4'd12, 32'h00001111, RESP_OKAY, 1'b0);
    push_r(4'd12, 32'h00002222, RESP_OKAY, 1'b1);
    ar_send(4'd12, 32'h300, 8'd1, BURST_INCR);
    drain();

    // FIXED burst keeps hitting the same word
    push_b(4'd13, RESP_OKAY);
    aw_send(4'd13, 32'h308, 8'd1, BURST_FIXED);
    w_send(32'h0000AAAA, 4'hF, 1'b0);
    w_send(32'h0000BBBB, 4'hF, 1'b1);
    drain();
    push_r(4'd14, 32'h0000BBBB, RESP_OKAY, 1'b0);
    push_r(4'd14, 32'h0000BBBB, RESP_OKAY, 1'b1);
    ar_send(4'd14, 32'h308, 8'd1, BURST_FIXED);
    drain();

    // same-cycle read and write to 0x40 returns the old word
    write1(4'd1, 32'h40, 32'h0BAD0000, 4'hF, RESP_OKAY);
    push_b(4'd2, RESP_OKAY);
    aw_send(4'd2, 32'h40, 8'd0, BURST_INCR);
    push_r(4'd3, 32'h0BAD0000, RESP_OKAY, 1'b1);
    fork
      ar_send(4'd3, 32'h40, 8'd0, BURST_INCR);
      w_send(32'h600DF00D, 4'hF, 1'b1);
    join
    drain();
    read1(4'd4, 32'h40, 32'h600DF00D, RESP_OKAY);

    // reset in the middle of a write burst
    aw_send(4'd10, 32'h400, 8'd3, BURST_INCR);
    w_send(32'h77777777, 4'hF, 1'b0);
    resetn = 1'b0;
    @(negedge clk);
    check("midburst_reset_outputs", 64'({arready, awready, wready, rvalid, rlast, bvalid, rid,
                                         bid, rresp, bresp, rdata}), 64'd0);
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    read1(4'd5, 32'h400, 32'h77777777, RESP_OKAY);
    write1(4'd6, 32'h404, 32'h12345678, 4'hF, RESP_OKAY);
    read1(4'd7, 32'h404, 32'h12345678, RESP_OKAY);

    repeat (5) @(posedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/axi_sram_slave.md
# axi_sram_slave

AXI3-style slave that answers the requests issued by the CPU-side AXI bridge and backs them with on-chip word memory. It serves single-beat and short INCR/FIXED bursts on independent read and write channels, with 32-bit data and 4-bit IDs. It returns IDs unchanged and reports DECERR for addresses outside the memory. It sits at the far end of the CPU's AXI port, as the simulation/FPGA memory target.

## Interface
- ADDR_W, 14: word-address bits; memory is 2^ADDR_W 32-bit words (64 KiB by default).
- clk  in  1  clock, all logic on rising edge.
- resetn  in  1  asynchronous, active-low reset.
- arid/araddr/arlen/arsize/arburst  in  4/32/8/3/2  read address; arlock/arcache/arprot accepted and ignored.
- arvalid in 1; arready out 1.
- rid/rdata/rresp/rlast/rvalid  out  4/32/2/1/1; rready in 1.
- awid/awaddr/awlen/awsize/awburst  in  4/32/8/3/2; awlock/awcache/awprot ignored; awvalid in 1; awready out 1.
- wid/wdata/wstrb/wlast/wvalid  in  4/32/4/1/1; wready out 1.
- bid/bresp/bvalid  out  4/2/1; bready in 1.

## Operation
- **Reset.** All outputs reset to 0. Both FSMs go to IDLE. A one-bit init flag clears. Memory contents are not reset.
- **Ready after reset.** init sets on the first clock edge after resetn rises. arready = R_IDLE & init. awready = W_IDLE & init.
- **Addressing.** Word index = addr[ADDR_W+1:2]. A beat is in range iff addr[31:ADDR_W+2] == 0.
- **Burst address.** INCR adds 4 per beat. FIXED holds the address. WRAP (2'b10) is treated as INCR.
- **Size.** arsize/awsize are not used for addressing. Narrow accesses rely on wstrb; reads always return the full word.
- **Burst length.** Beats = len+1. len is accepted up to 255. The beat counter is 8 bits.
- **Read FSM.**
  - R_IDLE: on AR handshake, latch id, addr, len, burst; issue memory read → R_FETCH.
  - R_FETCH: capture memory output into rdata → R_DATA.
  - R_DATA: rvalid=1. On rready, if last beat → R_IDLE; otherwise advance addr, issue read → R_FETCH.
  - rid = latched arid. rlast = (count == len).
  - Out-of-range beat: rdata=0, rresp=2'b11; otherwise 2'b00.
- **Write FSM.**
  - W_IDLE: on AW handshake, latch id, addr, len, burst; clear error flags → W_DATA.
  - W_DATA: wready=1. Each W handshake writes the bytes enabled by wstrb (in range only) and advances the count.
  - On the final counted beat → W_RESP.
  - W_RESP: bvalid=1, bid = latched awid. On bready → W_IDLE.
  - wid is ignored.
- **bresp priority.** DECERR(2'b11) if any beat was out of range. Else SLVERR(2'b10) if wlast disagreed with the beat count on any beat. Else OKAY.
- **Channel ordering.** The slave may accept W only after AW. This is legal; a master issuing W first simply waits.
- **Read/write concurrency.** Read and write FSMs are fully independent. A same-cycle read and write to the same word returns the old data (read-first).
- **Handshake stability.** rvalid, rdata, rresp, rlast, rid are stable while rvalid & !rready. bvalid, bresp, bid are stable while bvalid & !bready.
- **Reset mid-burst.** The transaction is abandoned. Memory writes already performed remain; no response is issued.

## Timing
- AR handshake at edge T → rvalid at T+2.
- Inside a burst, each next beat appears 2 cycles after the previous R handshake, so peak read rate is 1 beat per 2 cycles.
- AW handshake at T → wready at T+1. W beats are accepted one per cycle.
- Last W handshake at T → bvalid at T+1.
- arready/awready are low from the cycle after their handshake until the FSM returns to IDLE.
- A new AR (AW) is accepted no earlier than the cycle after the final R (B) handshake.

## Structure
- Shared package holds:
  - AXI response codes: OKAY 2'b00, SLVERR 2'b10, DECERR 2'b11.
  - Burst codes: FIXED 2'b00, INCR 2'b01, WRAP 2'b10.
  - Read and write FSM state enums.
- Sub-module sram_1r1w(DEPTH=2^ADDR_W): synchronous 1-read/1-write word RAM, byte-write enables, read-first, 1-cycle read latency.

## Test plan
- **Single-beat write/read.** AW addr 0x100, id 1, len 0; W 0xDEADBEEF, wstrb 0xF, wlast 1 → bvalid next cycle, bid 1, bresp 00. Then AR addr 0x100, id 0 → rvalid 2 cycles later, rdata 0xDEADBEEF, rid 0, rlast 1.
- **Byte strobes.** Write 0x11223344 then 0xAABBCCDD with wstrb 0x5 to the same word → read returns 0x11BB33DD.
- **INCR burst with backpressure.** Read burst, len 3, from 0x200 with rready toggled 1/0 → 4 beats with consecutive words. rlast only on beat 4. Outputs held stable while rready is 0.
- **Out of range.** AR addr 1<<(ADDR_W+2) → rdata 0, rresp 11. A write there → bresp 11 and memory unchanged.
- **wlast mismatch.** awlen 1 with wlast=1 on beat 1 → 2 beats written, bresp 10.
- **Concurrency and reset.** Simultaneous read and write to 0x40 → read returns the old value. resetn pulsed low during W_DATA → all outputs 0; the next transaction after reset completes normally.
